// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter for an asynchronous 16-bit SRAM.
// Each access holds the strobes for WAIT_CYCLES cycles, then spends one recovery cycle before returning to idle.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [19:0] addr0,
    input  logic [19:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata0,
    output logic [15:0] rdata1,
    output logic        busy,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE,
    output logic [19:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        tristate_output_enable
);

    typedef enum logic [1:0] {StIdle, StAccess, StRecover} state_e;

    localparam logic [3:0] CntInit = 4'(WAIT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        wr_q, wr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [15:0] rdata0_q, rdata0_d;
    logic [15:0] rdata1_q, rdata1_d;
    logic        busy_q, busy_d;
    logic        ce_q, ce_d;
    logic        ub_q, ub_d;
    logic        lb_q, lb_d;
    logic        oe_q, oe_d;
    logic        we_n_q, we_n_d;
    logic        toe_q, toe_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;

    logic        win;
    logic        win_we;

    // On a tie the port not granted last time wins.
    always_comb begin
        win    = (req0 && req1) ? ~last_q : req1;
        win_we = win ? we1 : we0;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        wr_d     = wr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        busy_d   = busy_q;
        ce_d     = ce_q;
        ub_d     = ub_q;
        lb_d     = lb_q;
        oe_d     = oe_q;
        we_n_d   = we_n_q;
        toe_d    = toe_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        unique case (state_q)
            StIdle: begin
                if (req0 || req1) begin
                    state_d = StAccess;
                    cnt_d   = CntInit;
                    gnt_d   = win;
                    last_d  = win;
                    wr_d    = win_we;
                    addr_d  = win ? addr1 : addr0;
                    if (win_we) begin
                        wdata_d = win ? wdata1 : wdata0;
                    end
                    busy_d  = 1'b1;
                    ce_d    = 1'b0;
                    ub_d    = 1'b0;
                    lb_d    = 1'b0;
                    oe_d    = win_we;
                    we_n_d  = ~win_we;
                    toe_d   = win_we;
                end
            end
            StAccess: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRecover;
                    if (!wr_q) begin
                        if (gnt_q) begin
                            rdata1_d = Data_from_SRAM;
                        end else begin
                            rdata0_d = Data_from_SRAM;
                        end
                    end
                    ack0_d = ~gnt_q;
                    ack1_d = gnt_q;
                    ce_d   = 1'b1;
                    ub_d   = 1'b1;
                    lb_d   = 1'b1;
                    oe_d   = 1'b1;
                    we_n_d = 1'b1;
                    toe_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRecover: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            wr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= 16'h0;
            rdata1_q <= 16'h0;
            busy_q   <= 1'b0;
            ce_q     <= 1'b1;
            ub_q     <= 1'b1;
            lb_q     <= 1'b1;
            oe_q     <= 1'b1;
            we_n_q   <= 1'b1;
            toe_q    <= 1'b0;
            addr_q   <= 20'h0;
            wdata_q  <= 16'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            wr_q     <= wr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            busy_q   <= busy_d;
            ce_q     <= ce_d;
            ub_q     <= ub_d;
            lb_q     <= lb_d;
            oe_q     <= oe_d;
            we_n_q   <= we_n_d;
            toe_q    <= toe_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign ack0                   = ack0_q;
    assign ack1                   = ack1_q;
    assign rdata0                 = rdata0_q;
    assign rdata1                 = rdata1_q;
    assign busy                   = busy_q;
    assign CE                     = ce_q;
    assign UB                     = ub_q;
    assign LB                     = lb_q;
    assign OE                     = oe_q;
    assign WE                     = we_n_q;
    assign ADDR                   = addr_q;
    assign Data_to_SRAM           = wdata_q;
    assign tristate_output_enable = toe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a WAIT_CYCLES=2 instance plus a WAIT_CYCLES=1 instance on shared inputs.
module tb_sram_arbiter;

    logic        Clk;
    logic        Reset;
    logic        req0, req1, we0, we1;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [15:0] Data_from_SRAM;

    logic        ack0, ack1, busy, CE, UB, LB, OE, WE, toe;
    logic [15:0] rdata0, rdata1, Data_to_SRAM;
    logic [19:0] ADDR;

    logic        w1_ack0, w1_ack1, w1_busy, w1_CE, w1_UB, w1_LB, w1_OE, w1_WE, w1_toe;
    logic [15:0] w1_rdata0, w1_rdata1, w1_dout;
    logic [19:0] w1_addr;

    logic [5:0]  strb, w1_strb;
    logic        use_addr_model;
    logic [15:0] sram_fixed;

    int checks = 0;
    int errors = 0;

    assign strb    = {CE, UB, LB, OE, WE, toe};
    assign w1_strb = {w1_CE, w1_UB, w1_LB, w1_OE, w1_WE, w1_toe};
    // SRAM model: either a fixed word or an address-derived word.
    assign Data_from_SRAM = use_addr_model ? (ADDR[15:0] ^ 16'hC0DE) : sram_fixed;

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
        .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .tristate_output_enable(toe)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(w1_ack0), .ack1(w1_ack1), .rdata0(w1_rdata0), .rdata1(w1_rdata1),
        .busy(w1_busy),
        .CE(w1_CE), .UB(w1_UB), .LB(w1_LB), .OE(w1_OE), .WE(w1_WE),
        .ADDR(w1_addr), .Data_to_SRAM(w1_dout), .Data_from_SRAM(Data_from_SRAM),
        .tristate_output_enable(w1_toe)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        cycle();
        cycle();
        checks++;
        if (strb !== 6'b111110) begin
            errors++; $display("FAIL reset_strobes: got %b want %b", strb, 6'b111110);
        end
        checks++;
        if ({ack0, ack1, busy} !== 3'b000) begin
            errors++; $display("FAIL reset_ack_busy: got %b want 000", {ack0, ack1, busy});
        end
        checks++;
        if (ADDR !== 20'h0 || Data_to_SRAM !== 16'h0) begin
            errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", ADDR, Data_to_SRAM);
        end
        checks++;
        if (rdata0 !== 16'h0 || rdata1 !== 16'h0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", rdata0, rdata1);
        end
        checks++;
        if (w1_strb !== 6'b111110 || w1_busy !== 1'b0) begin
            errors++; $display("FAIL reset_w1: got %b/%b want 111110/0", w1_strb, w1_busy);
        end
        Reset = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00030;
        use_addr_model = 1'b0; sram_fixed = 16'h7777;
        cycle();
        checks++;
        if (strb !== 6'b000010) begin
            errors++; $display("FAIL abort_c1_strobes: got %b want 000010", strb);
        end
        cycle();
        checks++;
        if (strb !== 6'b000010 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_c2: got %b/%b want 000010/1", strb, busy);
        end
        Reset = 1'b0;
        req0  = 1'b0;
        cycle();
        checks++;
        if (strb !== 6'b111110 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_c3: got %b/%b want 111110/0", strb, busy);
        end
        checks++;
        if ({ack0, ack1} !== 2'b00 || rdata0 !== 16'h0) begin
            errors++; $display("FAIL abort_c3_ack_rdata: got %b/%h want 00/0000", {ack0, ack1}, rdata0);
        end
        Reset = 1'b1;
        cycle();
        checks++;
        if ({ack0, busy} !== 2'b00 || rdata0 !== 16'h0) begin
            errors++; $display("FAIL abort_c4: got %b/%h want 00/0000", {ack0, busy}, rdata0);
        end
    endtask

    task automatic test_single_read();
        logic [5:0]  exp_strb [4] = '{6'b000010, 6'b000010, 6'b111110, 6'b111110};
        logic [3:0]  exp_ack0 = 4'b0100;
        logic [3:0]  exp_busy = 4'b0111;
        logic [15:0] exp_rd;
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00010;
        use_addr_model = 1'b0; sram_fixed = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            cycle();
            exp_rd = (i >= 2) ? 16'hBEEF : 16'h0000;
            checks++;
            if (strb !== exp_strb[i]) begin
                errors++; $display("FAIL read_strobes c%0d: got %b want %b", i + 1, strb, exp_strb[i]);
            end
            checks++;
            if ({ack0, ack1, busy} !== {exp_ack0[i], 1'b0, exp_busy[i]}) begin
                errors++; $display("FAIL read_ack_busy c%0d: got %b want %b", i + 1,
                                   {ack0, ack1, busy}, {exp_ack0[i], 1'b0, exp_busy[i]});
            end
            checks++;
            if (ADDR !== 20'h00010 || rdata0 !== exp_rd) begin
                errors++; $display("FAIL read_addr_rdata c%0d: got %h/%h want 00010/%h", i + 1,
                                   ADDR, rdata0, exp_rd);
            end
            if (i == 2) req0 = 1'b0;
        end
        checks++;
        if (rdata1 !== 16'h0) begin
            errors++; $display("FAIL read_rdata1: got %h want 0000", rdata1);
        end
    endtask

    task automatic test_single_write();
        logic [5:0] exp_strb [4] = '{6'b000101, 6'b000101, 6'b111110, 6'b111110};
        logic [3:0] exp_ack1 = 4'b0100;
        req1 = 1'b1; we1 = 1'b1; addr1 = 20'h0FFFF; wdata1 = 16'h1234;
        use_addr_model = 1'b0; sram_fixed = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (strb !== exp_strb[i]) begin
                errors++; $display("FAIL write_strobes c%0d: got %b want %b", i + 1, strb, exp_strb[i]);
            end
            checks++;
            if ({ack0, ack1} !== {1'b0, exp_ack1[i]}) begin
                errors++; $display("FAIL write_ack c%0d: got %b want %b", i + 1, {ack0, ack1},
                                   {1'b0, exp_ack1[i]});
            end
            checks++;
            if (ADDR !== 20'h0FFFF || Data_to_SRAM !== 16'h1234) begin
                errors++; $display("FAIL write_addr_data c%0d: got %h/%h want 0ffff/1234", i + 1,
                                   ADDR, Data_to_SRAM);
            end
            if (i == 2) req1 = 1'b0;
        end
        checks++;
        if (rdata1 !== 16'h0 || rdata0 !== 16'hBEEF) begin
            errors++; $display("FAIL write_rdata_kept: got %h/%h want beef/0000", rdata0, rdata1);
        end
        we1 = 1'b0;
    endtask

    task automatic test_dropped_request();
        logic [7:0] exp_ack0 = 8'b0000_0100;
        logic [7:0] exp_busy = 8'b0000_0111;
        logic [7:0] exp_ce_n = 8'b1111_1100;
        int         n_ack = 0;
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00040;
        use_addr_model = 1'b0; sram_fixed = 16'h1357;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (i == 0) req0 = 1'b0;
            if (ack0 === 1'b1) n_ack++;
            checks++;
            if ({ack0, busy, CE} !== {exp_ack0[i], exp_busy[i], exp_ce_n[i]}) begin
                errors++; $display("FAIL drop_c%0d: got ack/busy/ce %b want %b", i + 1,
                                   {ack0, busy, CE}, {exp_ack0[i], exp_busy[i], exp_ce_n[i]});
            end
        end
        checks++;
        if (n_ack != 1 || rdata0 !== 16'h1357) begin
            errors++; $display("FAIL drop_summary: got acks %0d rdata0 %h want 1/1357", n_ack, rdata0);
        end
    endtask

    task automatic test_contention();
        logic        e0, e1;
        logic [19:0] e_addr;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 20'h00100; addr1 = 20'h00200;
        use_addr_model = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            cycle();
            e0     = (c == 3) || (c == 11);
            e1     = (c == 7) || (c == 15);
            e_addr = ((((c - 1) / 4) % 2) == 0) ? 20'h00100 : 20'h00200;
            checks++;
            if ({ack0, ack1} !== {e0, e1}) begin
                errors++; $display("FAIL contend_ack c%0d: got %b want %b", c, {ack0, ack1}, {e0, e1});
            end
            checks++;
            if (ADDR !== e_addr) begin
                errors++; $display("FAIL contend_addr c%0d: got %h want %h", c, ADDR, e_addr);
            end
            if (c == 15) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        checks++;
        if (rdata0 !== 16'hC1DE || rdata1 !== 16'hC2DE) begin
            errors++; $display("FAIL contend_rdata: got %h/%h want c1de/c2de", rdata0, rdata1);
        end
        use_addr_model = 1'b0;
    endtask

    task automatic test_wait1();
        logic [6:0] exp_ack0 = 7'b0010010;
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00055;
        use_addr_model = 1'b0; sram_fixed = 16'h2468;
        for (int i = 0; i < 7; i++) begin
            cycle();
            checks++;
            if ({w1_ack0, w1_ack1} !== {exp_ack0[i], 1'b0}) begin
                errors++; $display("FAIL w1_ack c%0d: got %b want %b", i + 1, {w1_ack0, w1_ack1},
                                   {exp_ack0[i], 1'b0});
            end
            checks++;
            if (w1_CE !== ((i % 3) != 0) || w1_busy !== ((i % 3) != 2)) begin
                errors++; $display("FAIL w1_ce_busy c%0d: got %b%b want %b%b", i + 1, w1_CE, w1_busy,
                                   ((i % 3) != 0), ((i % 3) != 2));
            end
        end
        req0 = 1'b0;
        cycle();
        cycle();
        checks++;
        if (w1_rdata0 !== 16'h2468 || w1_busy !== 1'b0) begin
            errors++; $display("FAIL w1_rdata: got %h/%b want 2468/0", w1_rdata0, w1_busy);
        end
    endtask

    initial begin
        Reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 20'h0; addr1 = 20'h0; wdata0 = 16'h0; wdata1 = 16'h0;
        use_addr_model = 1'b0; sram_fixed = 16'h0;
        test_reset();
        test_reset_mid_access();
        test_single_read();
        test_single_write();
        test_dropped_request();
        test_reset();
        test_contention();
        test_reset();
        test_wait1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of cycles the SRAM strobes are held active per access (legal 1..15).
REQ-002 Clk  in  1  system clock; all state updates on rising edge.
REQ-003 Reset  in  1  synchronous, active-low reset, sampled on rising Clk.
REQ-004 req0, req1  in  1 each  access request; port 0 is the CPU (Mem2IO side), port 1 is the program loader/debug port.
REQ-005 we0, we1  in  1 each  1 = write, 0 = read; sampled with the request.
REQ-006 addr0, addr1  in  20 each  SRAM word address.
REQ-007 wdata0, wdata1  in  16 each  write data.
REQ-008 ack0, ack1  out  1 each  one-cycle pulse; access for that port complete.
REQ-009 rdata0, rdata1  out  16 each  last read data returned to that port.
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 CE, UB, LB, OE, WE  out  1 each  active-low SRAM strobes.
REQ-012 ADDR  out  20  SRAM address; Data_to_SRAM  out  16; Data_from_SRAM  in  16; tristate_output_enable  out  1 (drive bus when high).

Function
REQ-013 FSM states IDLE, ACCESS, RECOVER; all outputs registered.
REQ-014 IDLE: if any req sampled high, latch winning port, its we/addr/wdata into internal registers; go ACCESS with counter = WAIT_CYCLES-1; else stay IDLE.
REQ-015 Arbitration: single request wins; both high -> port not granted last time wins (round-robin); last-grant pointer updates on every grant.
REQ-016 ACCESS: CE=UB=LB=0; read -> OE=0, WE=1, tristate_output_enable=0; write -> OE=1, WE=0, tristate_output_enable=1, Data_to_SRAM = latched wdata.
REQ-017 ACCESS: counter decrements each cycle; on the edge where counter==0, read data Data_from_SRAM captured into rdata of granted port, ack of granted port set, state -> RECOVER.
REQ-018 RECOVER: all strobes high, tristate_output_enable=0, ADDR held, ack high for exactly this cycle; next state IDLE unconditionally.
REQ-019 Latency (WAIT_CYCLES=2): req high before edge 1 -> ACCESS cycles 1-2 -> ack cycle 3 -> IDLE cycle 4; request-to-ack = WAIT_CYCLES+1 cycles; max throughput one access per WAIT_CYCLES+2 cycles.
REQ-020 ADDR stable from first ACCESS cycle through RECOVER; no strobe changes within ACCESS.
REQ-021 Requests sampled only in IDLE; req changes during ACCESS/RECOVER ignored; a dropped req mid-access still completes and still acks.
REQ-022 Requester holds req until its ack; req still high in the IDLE after ack is a new request.
REQ-023 rdata of a port changes only on that port's read completion; writes and other-port accesses leave it unchanged.
REQ-024 ack0 and ack1 never high in the same cycle.

Reset
REQ-025 Reset low at an edge -> state IDLE, CE=UB=LB=OE=WE=1, tristate_output_enable=0, ack0=ack1=0, busy=0, ADDR=0, Data_to_SRAM=0, rdata0=rdata1=0, last-grant pointer = port 1 (port 0 wins first tie).
REQ-026 Reset mid-ACCESS or RECOVER aborts the access with no ack and no rdata update; strobes high on the following cycle.

Verification
REQ-027 Single read, WAIT_CYCLES=2: req0=1, we0=0, addr0=0x00010, SRAM returns 0xBEEF -> OE=0/CE=0 cycles 1-2, ack0 cycle 3, rdata0=0xBEEF, rdata1 unchanged.
REQ-028 Single write: req1=1, we1=1, addr1=0x0FFFF, wdata1=0x1234 -> WE=0 and tristate_output_enable=1 for 2 cycles, Data_to_SRAM=0x1234, ADDR=0x0FFFF, ack1 cycle 3, OE stays 1.
REQ-029 Contention after reset: req0=req1=1 held continuously -> grants alternate 0,1,0,1; acks at cycles 3,7,11,15; never simultaneous.
REQ-030 Reset mid-access: assert Reset low during second ACCESS cycle -> next cycle all strobes 1, busy=0, no ack pulse, rdata unchanged.
REQ-031 Dropped request: req0 pulsed for one cycle only -> access still runs full WAIT_CYCLES, ack0 still pulses once, no second access.
REQ-032 WAIT_CYCLES=1 build: read completes with one ACCESS cycle, ack at cycle 2, back-to-back period 3 cycles.
